// File: rtl/store_pkg.sv
// -----------------------------------------------------------------------------
// store_pkg
// Shared definitions for the store unit: funct3 encodings of the supported
// store widths, the FSM state type and small decode helpers.
// No ports (package).
// -----------------------------------------------------------------------------
package store_pkg;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  // True for the three store widths the unit can issue.
  function automatic logic f3_legal(input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_SB:   ok = 1'b1;
      F3_SH:   ok = 1'b1;
      F3_SW:   ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // True when the low address bits are not naturally aligned for the width.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic mis;
    case (f3)
      F3_SH:   mis = lo[0];
      F3_SW:   mis = (lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/store_align.sv
// -----------------------------------------------------------------------------
// store_align
// Combinational lane steering for a store: byte enables from width and the
// low address bits, write data replicated across all lanes so the memory
// picks whichever lanes are enabled.
// Ports:
//   funct3  in  3   store width (SB/SH/SW)
//   addr_lo in  2   byte address bits [1:0]
//   data    in  32  LSB-justified store data
//   be      out 4   byte enables
//   wdata   out 32  lane-replicated write data
// Misaligned halfword/word offsets simply drop the offending low bits.
// -----------------------------------------------------------------------------
module store_align
  import store_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data,
  output logic [3:0]  be,
  output logic [31:0] wdata
);

  // Width decode to byte enables and replicated data.
  always_comb begin
    be    = 4'b0000;
    wdata = 32'h0000_0000;
    case (funct3)
      F3_SB: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{data[7:0]}};
      end
      F3_SH: begin
        be    = 4'b0011 << {addr_lo[1], 1'b0};
        wdata = {2{data[15:0]}};
      end
      F3_SW: begin
        be    = 4'b1111;
        wdata = data;
      end
      default: begin
        be    = 4'b0000;
        wdata = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/store_unit.sv
// -----------------------------------------------------------------------------
// store_unit
// Issues one pipeline store to data memory and waits for its acknowledge,
// aborting with an error pulse if no acknowledge arrives within
// TIMEOUT_CYCLES request cycles.
// Optional feature macro: STORE_MISALIGN_TRAP_EN -- when defined, misaligned
// SH/SW requests are refused with a misalign_o pulse instead of being issued
// with their low address bits dropped.
// Ports:
//   clk_i        in  1   clock, rising edge
//   rst_i        in  1   synchronous active-high reset
//   mem_write_i  in  1   store request (sampled only in IDLE)
//   funct3_i     in  3   store width
//   addr_i       in  32  byte address
//   data_i       in  32  store data, LSB-justified
//   dmem_we_o    out 1   write strobe, high for every REQ cycle
//   dmem_addr_o  out 32  word address
//   dmem_wdata_o out 32  lane-replicated write data
//   dmem_be_o    out 4   byte enables
//   dmem_ack_i   in  1   memory accepted the write
//   busy_o       out 1   unit in REQ
//   done_o       out 1   pulse: store acknowledged
//   err_o        out 1   pulse: illegal funct3 or timeout
//   misalign_o   out 1   pulse: misaligned store refused (macro builds only)
// -----------------------------------------------------------------------------
module store_unit
  import store_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic        dmem_ack_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic        misalign_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             capture;
  logic             done_next;
  logic             err_next;
  logic             mis_next;
  logic             misaligned;
  logic [3:0]       align_be;
  logic [31:0]      align_wdata;

  store_align u_align (
    .funct3  (funct3_i),
    .addr_lo (addr_i[1:0]),
    .data    (data_i),
    .be      (align_be),
    .wdata   (align_wdata)
  );

`ifdef STORE_MISALIGN_TRAP_EN
  assign misaligned = is_misaligned(funct3_i, addr_i[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  // State and request-cycle counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= CNT_ZERO;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
    end
  end

  // Next-state, counter and completion-pulse decode.
  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    done_next  = 1'b0;
    err_next   = 1'b0;
    mis_next   = 1'b0;
    case (state)
      IDLE: begin
        cnt_next = CNT_ZERO;
        if (mem_write_i) begin
          if (!f3_legal(funct3_i)) begin
            err_next = 1'b1;
          end else if (misaligned) begin
            mis_next = 1'b1;
          end else begin
            next_state = REQ;
            capture    = 1'b1;
            cnt_next   = CNT_ONE;
          end
        end else begin
          next_state = IDLE;
        end
      end
      REQ: begin
        // Acknowledge wins over a timeout landing in the same cycle.
        if (dmem_ack_i) begin
          next_state = IDLE;
          cnt_next   = CNT_ZERO;
          done_next  = 1'b1;
        end else if (cnt == CNT_MAX) begin
          next_state = IDLE;
          cnt_next   = CNT_ZERO;
          err_next   = 1'b1;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      default: begin
        next_state = IDLE;
        cnt_next   = CNT_ZERO;
      end
    endcase
  end

  // Registered memory-side fields, captured once when a request is accepted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dmem_addr_o  <= 32'h0000_0000;
      dmem_wdata_o <= 32'h0000_0000;
      dmem_be_o    <= 4'b0000;
    end else if (capture) begin
      dmem_addr_o  <= {addr_i[31:2], 2'b00};
      dmem_wdata_o <= align_wdata;
      dmem_be_o    <= align_be;
    end else begin
      dmem_addr_o  <= dmem_addr_o;
      dmem_wdata_o <= dmem_wdata_o;
      dmem_be_o    <= dmem_be_o;
    end
  end

  // Registered strobes and status pulses; strobes mirror the REQ state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dmem_we_o  <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      misalign_o <= 1'b0;
    end else begin
      dmem_we_o  <= (next_state == REQ);
      busy_o     <= (next_state == REQ);
      done_o     <= done_next;
      err_o      <= err_next;
      misalign_o <= mis_next;
    end
  end

endmodule

// File: tb/tb_store_unit.sv
// -----------------------------------------------------------------------------
// tb_store_unit
// Self-checking bench for store_unit: a table of store requests with their
// expected lane steering and outcome, applied back to back through a
// scoreboard queue, plus a hand-written reset-during-REQ sequence.
// -----------------------------------------------------------------------------
module tb_store_unit;
  import store_pkg::*;

  localparam int O_DONE = 0;
  localparam int O_ERR  = 1;
  localparam int O_MIS  = 2;
  localparam int NV     = 12;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    int          ack_at;    // REQ cycle (1-based) carrying the ack; 0 = never
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] daddr;
    int          outcome;
    int          we_cycles;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] data;
  logic        we;
  logic [31:0] daddr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        ack;
  logic        busy;
  logic        done;
  logic        err;
  logic        mis;

  int errors = 0;
  int checks = 0;

  vec_t vecs[NV];
  vec_t sb[$];

  always #5 clk = ~clk;

  store_unit #(.TIMEOUT_CYCLES(15)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .mem_write_i  (mem_write),
    .funct3_i     (funct3),
    .addr_i       (addr),
    .data_i       (data),
    .dmem_we_o    (we),
    .dmem_addr_o  (daddr),
    .dmem_wdata_o (wdata),
    .dmem_be_o    (be),
    .dmem_ack_i   (ack),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .misalign_o   (mis)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one request, follow it to its completion pulse, score it.
  task automatic run_vec(input int idx, input vec_t v);
    vec_t e;
    int   we_n;
    int   got;
    bit   fin;
    mem_write = 1'b1;
    funct3    = v.f3;
    addr      = v.addr;
    data      = v.data;
    sb.push_back(v);
    tick();
    // Junk request held during REQ must be ignored.
    mem_write = 1'b1;
    funct3    = 3'b000;
    addr      = 32'hFFFF_FFFF;
    data      = 32'h0000_0000;
    we_n = 0;
    got  = -1;
    fin  = 1'b0;
    for (int c = 0; c < 40 && !fin; c++) begin
      if (done || err || mis) begin
        got = done ? O_DONE : (err ? O_ERR : O_MIS);
        chk($sformatf("v%0d_pulse_onehot", idx), 32'($countones({done, err, mis})), 32'd1);
        fin = 1'b1;
      end else if (we) begin
        we_n++;
        e = sb[0];
        chk($sformatf("v%0d_daddr", idx), daddr, e.daddr);
        chk($sformatf("v%0d_be", idx), {28'd0, be}, {28'd0, e.be});
        chk($sformatf("v%0d_wdata", idx), wdata, e.wdata);
        chk($sformatf("v%0d_busy", idx), {31'd0, busy}, 32'd1);
        ack = (we_n == e.ack_at);
        if (ack) mem_write = 1'b0;
        tick();
      end else begin
        got = -2;
        fin = 1'b1;
      end
    end
    ack       = 1'b0;
    mem_write = 1'b0;
    if (!fin) chk($sformatf("v%0d_bound", idx), 32'd0, 32'd1);
    e = sb.pop_front();
    chk($sformatf("v%0d_outcome", idx), got, e.outcome);
    chk($sformatf("v%0d_we_cycles", idx), we_n, e.we_cycles);
    chk($sformatf("v%0d_we_end", idx), {31'd0, we}, 32'd0);
    chk($sformatf("v%0d_busy_end", idx), {31'd0, busy}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{3'b000, 32'h0000_1003, 32'h0000_00A5, 3, 4'b1000, 32'hA5A5_A5A5, 32'h0000_1000, O_DONE, 3};
    vecs[1]  = '{3'b001, 32'h0000_2002, 32'h1234_BEEF, 1, 4'b1100, 32'hBEEF_BEEF, 32'h0000_2000, O_DONE, 1};
    vecs[2]  = '{3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 0, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0010, O_ERR, 15};
    vecs[3]  = '{3'b011, 32'h0000_0020, 32'h1111_1111, 0, 4'b0000, 32'h0, 32'h0, O_ERR, 0};
`ifdef STORE_MISALIGN_TRAP_EN
    vecs[4]  = '{3'b010, 32'h0000_0011, 32'hCAFE_F00D, 0, 4'b0000, 32'h0, 32'h0, O_MIS, 0};
    vecs[8]  = '{3'b001, 32'h0000_3003, 32'h0000_C3C3, 0, 4'b0000, 32'h0, 32'h0, O_MIS, 0};
`else
    vecs[4]  = '{3'b010, 32'h0000_0011, 32'hCAFE_F00D, 2, 4'b1111, 32'hCAFE_F00D, 32'h0000_0010, O_DONE, 2};
    vecs[8]  = '{3'b001, 32'h0000_3003, 32'h0000_C3C3, 1, 4'b1100, 32'hC3C3_C3C3, 32'h0000_3000, O_DONE, 1};
`endif
    vecs[5]  = '{3'b000, 32'h0000_2000, 32'h1234_5678, 1, 4'b0001, 32'h7878_7878, 32'h0000_2000, O_DONE, 1};
    vecs[6]  = '{3'b000, 32'h0000_2001, 32'h0000_00FF, 2, 4'b0010, 32'hFFFF_FFFF, 32'h0000_2000, O_DONE, 2};
    vecs[7]  = '{3'b001, 32'h0000_3000, 32'hAAAA_5555, 4, 4'b0011, 32'h5555_5555, 32'h0000_3000, O_DONE, 4};
    vecs[9]  = '{3'b111, 32'h0000_0040, 32'h2222_2222, 0, 4'b0000, 32'h0, 32'h0, O_ERR, 0};
    vecs[10] = '{3'b010, 32'hABCD_0004, 32'h0BAD_F00D, 15, 4'b1111, 32'h0BAD_F00D, 32'hABCD_0004, O_DONE, 15};
    vecs[11] = '{3'b000, 32'h0000_0502, 32'h0000_003C, 1, 4'b0100, 32'h3C3C_3C3C, 32'h0000_0500, O_DONE, 1};

    rst = 1'b1; mem_write = 1'b0; funct3 = 3'b000; addr = 32'h0; data = 32'h0; ack = 1'b0;
    tick();
    tick();
    chk("rst_we",    {31'd0, we},   32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_pulses", {29'd0, done, err, mis}, 32'd0);
    chk("rst_daddr", daddr, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_be",    {28'd0, be},   32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // Reset in the third REQ cycle, with ack and a new request competing.
    mem_write = 1'b1; funct3 = 3'b010; addr = 32'h0000_0040; data = 32'h1122_3344;
    tick();
    mem_write = 1'b0;
    tick();
    tick();
    chk("rr_in_req3", {31'd0, we}, 32'd1);
    rst = 1'b1; ack = 1'b1; mem_write = 1'b1; funct3 = 3'b010; addr = 32'h0000_0080;
    tick();
    chk("rr_we",     {31'd0, we},   32'd0);
    chk("rr_busy",   {31'd0, busy}, 32'd0);
    chk("rr_pulses", {29'd0, done, err, mis}, 32'd0);
    chk("rr_daddr",  daddr, 32'd0);
    chk("rr_wdata",  wdata, 32'd0);
    chk("rr_be",     {28'd0, be},   32'd0);
    rst = 1'b0; mem_write = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("idle_ack_%0d", k), {28'd0, we, busy, done, err}, 32'd0);
    end
    ack = 1'b0;
    run_vec(NV, vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
